// File: rtl/fetch_stage.sv
// ---------------------------------------------------------------------------
// fetch_stage
//   Instruction-fetch stage. Owns the program counter, presents it to the
//   instruction memory (combinational read), and captures the returned word
//   into the IF/ID pipeline register. Supports stalls, branch/jump redirects
//   (which flush IF/ID with a NOP bubble) and halting at the end of program.
//
// Ports
//   clk          in   1   rising-edge clock
//   rst_n        in   1   asynchronous active-low reset
//   imem_addr    out  32  byte address to instruction memory (= PC register)
//   imem_data    in   32  instruction word, valid in the same cycle
//   stall        in   1   hold PC, state and IF/ID
//   redirect     in   1   taken branch/jump: load redirect_pc, flush IF/ID
//   redirect_pc  in   32  redirect target (forced to word alignment)
//   ifid_instr   out  32  registered instruction
//   ifid_pc      out  32  registered PC of ifid_instr
//   ifid_pc4     out  32  registered ifid_pc + 4
//   ifid_valid   out  1   IF/ID holds a real instruction
//   halted       out  1   fetch has stopped at or beyond END_ADDR
// ---------------------------------------------------------------------------
module fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h0000_0000,
    parameter int          NUM_INSTR = 34,
    parameter logic [31:0] NOP_INSTR = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_data,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    output logic [31:0] ifid_instr,
    output logic [31:0] ifid_pc,
    output logic [31:0] ifid_pc4,
    output logic        ifid_valid,
    output logic        halted
);

    localparam logic [31:0] END_ADDR   = 32'(NUM_INSTR * 4);
    localparam logic [31:0] ALIGN_MASK = 32'hFFFF_FFFC;

    typedef enum logic [0:0] {
        ST_RUN  = 1'b0,
        ST_HALT = 1'b1
    } state_t;

    // A PC at or beyond END_ADDR has nothing left to fetch.
    function automatic logic past_end(input logic [31:0] addr);
        past_end = (addr >= END_ADDR);
    endfunction

    localparam logic RESET_HALT = (RESET_PC >= END_ADDR);

    logic [31:0] pc_r;
    state_t      state_r;
    logic        halted_r;
    logic [31:0] ifid_instr_r;
    logic [31:0] ifid_pc_r;
    logic [31:0] ifid_pc4_r;
    logic        ifid_valid_r;

    logic [31:0] pc_plus4_s;
    logic [31:0] target_s;

    // Sequential PC increment (wraps modulo 2^32) and aligned redirect target.
    assign pc_plus4_s = pc_r + 32'd4;
    assign target_s   = redirect_pc & ALIGN_MASK;

    // PC, run/halt state and IF/ID register; priority redirect > stall > advance.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc_r         <= RESET_PC;
            state_r      <= RESET_HALT ? ST_HALT : ST_RUN;
            halted_r     <= RESET_HALT;
            ifid_instr_r <= NOP_INSTR;
            ifid_pc_r    <= 32'h0000_0000;
            ifid_pc4_r   <= 32'h0000_0000;
            ifid_valid_r <= 1'b0;
        end else if (redirect) begin
            // Flush: bubble into IF/ID, but ifid_pc/ifid_pc4 keep their values.
            pc_r         <= target_s;
            ifid_instr_r <= NOP_INSTR;
            ifid_valid_r <= 1'b0;
            if (past_end(target_s)) begin
                state_r  <= ST_HALT;
                halted_r <= 1'b1;
            end else begin
                state_r  <= ST_RUN;
                halted_r <= 1'b0;
            end
        end else if (stall) begin
            pc_r         <= pc_r;
            ifid_instr_r <= ifid_instr_r;
            ifid_valid_r <= ifid_valid_r;
        end else begin
            case (state_r)
                ST_RUN: begin
                    ifid_instr_r <= imem_data;
                    ifid_pc_r    <= pc_r;
                    ifid_pc4_r   <= pc_plus4_s;
                    ifid_valid_r <= 1'b1;
                    pc_r         <= pc_plus4_s;
                    if (past_end(pc_plus4_s)) begin
                        state_r  <= ST_HALT;
                        halted_r <= 1'b1;
                    end else begin
                        state_r  <= ST_RUN;
                        halted_r <= 1'b0;
                    end
                end
                ST_HALT: begin
                    // Drain: PC parked, bubbles flow into decode.
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
                default: begin
                    state_r      <= ST_HALT;
                    halted_r     <= 1'b1;
                    ifid_instr_r <= NOP_INSTR;
                    ifid_valid_r <= 1'b0;
                end
            endcase
        end
    end

    assign imem_addr  = pc_r;
    assign ifid_instr = ifid_instr_r;
    assign ifid_pc    = ifid_pc_r;
    assign ifid_pc4   = ifid_pc4_r;
    assign ifid_valid = ifid_valid_r;
    assign halted     = halted_r;

endmodule

// File: tb/tb_fetch_stage.sv
// ---------------------------------------------------------------------------
// tb_fetch_stage
//   Directed bench for fetch_stage. Instance A uses the default parameters and
//   is checked every cycle against a behavioural model; instance B starts at
//   RESET_PC = 0xFFFF_FFFC to exercise reset-into-halt.
// ---------------------------------------------------------------------------
module tb_fetch_stage;

    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] END_ADDR = 32'd136;
    localparam logic [31:0] TAG      = 32'hA000_0000;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [31:0] imem_addr, imem_data, redirect_pc;
    logic        stall, redirect;
    logic [31:0] ifid_instr, ifid_pc, ifid_pc4;
    logic        ifid_valid, halted;

    logic [31:0] imem_addr_b, imem_data_b, redirect_pc_b;
    logic        stall_b, redirect_b;
    logic [31:0] ifid_instr_b, ifid_pc_b, ifid_pc4_b;
    logic        ifid_valid_b, halted_b;

    int checks   = 0;
    int failures = 0;
    logic cmp_en = 1'b0;

    // Model state for instance A
    logic [31:0] m_pc, m_instr, m_ipc, m_ipc4;
    logic        m_valid;

    always #5 clk = ~clk;

    // Memory image: each word encodes its own address.
    assign imem_data   = TAG | imem_addr;
    assign imem_data_b = TAG | imem_addr_b;

    fetch_stage dut_a (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr), .imem_data(imem_data),
        .stall(stall), .redirect(redirect), .redirect_pc(redirect_pc),
        .ifid_instr(ifid_instr), .ifid_pc(ifid_pc), .ifid_pc4(ifid_pc4),
        .ifid_valid(ifid_valid), .halted(halted)
    );

    fetch_stage #(.RESET_PC(32'hFFFF_FFFC), .NUM_INSTR(34), .NOP_INSTR(32'h0000_0013)) dut_b (
        .clk(clk), .rst_n(rst_n), .imem_addr(imem_addr_b), .imem_data(imem_data_b),
        .stall(stall_b), .redirect(redirect_b), .redirect_pc(redirect_pc_b),
        .ifid_instr(ifid_instr_b), .ifid_pc(ifid_pc_b), .ifid_pc4(ifid_pc4_b),
        .ifid_valid(ifid_valid_b), .halted(halted_b)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: fetching is possible exactly while the PC lies below END_ADDR.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_pc    <= 32'h0;
            m_instr <= NOP;
            m_ipc   <= 32'h0;
            m_ipc4  <= 32'h0;
            m_valid <= 1'b0;
        end else if (redirect) begin
            m_pc    <= {redirect_pc[31:2], 2'b00};
            m_instr <= NOP;
            m_valid <= 1'b0;
        end else if (stall) begin
            m_pc <= m_pc;
        end else if (m_pc < END_ADDR) begin
            m_instr <= TAG | m_pc;
            m_ipc   <= m_pc;
            m_ipc4  <= m_pc + 32'd4;
            m_valid <= 1'b1;
            m_pc    <= m_pc + 32'd4;
        end else begin
            m_instr <= NOP;
            m_valid <= 1'b0;
        end
    end

    // Every-cycle comparison of instance A against the model.
    always @(negedge clk) begin
        if (cmp_en) begin
            chk("m_imem_addr",  imem_addr,  m_pc);
            chk("m_ifid_instr", ifid_instr, m_instr);
            chk("m_ifid_pc",    ifid_pc,    m_ipc);
            chk("m_ifid_pc4",   ifid_pc4,   m_ipc4);
            chk("m_ifid_valid", {31'd0, ifid_valid}, {31'd0, m_valid});
            chk("m_halted",     {31'd0, halted},     {31'd0, (m_pc >= END_ADDR)});
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic st, input logic rd, input logic [31:0] rpc);
        @(negedge clk);
        #1;
        stall       = st;
        redirect    = rd;
        redirect_pc = rpc;
    endtask

    initial begin
        rst_n = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = 32'h0;
        stall_b = 1'b0; redirect_b = 1'b0; redirect_pc_b = 32'h0;
        step();
        cmp_en = 1'b1;
        step();
        // Reset values
        chk("rst_imem_addr", imem_addr, 32'h0);
        chk("rst_instr", ifid_instr, 32'h0000_0013);
        chk("rst_valid", {31'd0, ifid_valid}, 32'd0);
        chk("rst_halted", {31'd0, halted}, 32'd0);
        chk("b_rst_halted", {31'd0, halted_b}, 32'd1);
        chk("b_rst_addr", imem_addr_b, 32'hFFFF_FFFC);

        // Test 1: three edges after release
        @(negedge clk); rst_n = 1'b1;
        step(); step(); step();
        chk("t1_pc", ifid_pc, 32'd8);
        chk("t1_instr", ifid_instr, 32'hA000_0008);
        chk("t1_pc4", ifid_pc4, 32'd12);
        chk("t1_valid", {31'd0, ifid_valid}, 32'd1);
        chk("t1_addr", imem_addr, 32'd12);

        // Test 2: stall two edges with pc=8
        @(negedge clk); rst_n = 1'b0;
        @(negedge clk); rst_n = 1'b1;
        step(); step();
        drive(1'b1, 1'b0, 32'h0);
        step(); step();
        chk("t2_stall_addr", imem_addr, 32'd8);
        chk("t2_stall_pc", ifid_pc, 32'd4);
        chk("t2_stall_instr", ifid_instr, 32'hA000_0004);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("t2_pc", ifid_pc, 32'd8);
        chk("t2_addr", imem_addr, 32'd12);

        // Test 3: redirect overrides stall, target aligned
        drive(1'b1, 1'b1, 32'h0000_0006);
        step();
        chk("t3_addr", imem_addr, 32'd4);
        chk("t3_instr", ifid_instr, 32'h0000_0013);
        chk("t3_valid", {31'd0, ifid_valid}, 32'd0);
        chk("t3_pc_hold", ifid_pc, 32'd8);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("t3_next_pc", ifid_pc, 32'd4);
        chk("t3_next_valid", {31'd0, ifid_valid}, 32'd1);

        // Test 4: free run to halt
        for (int i = 0; i < 100 && !halted; i++) step();
        chk("t4_halted", {31'd0, halted}, 32'd1);
        chk("t4_addr", imem_addr, 32'd136);
        chk("t4_last_pc", ifid_pc, 32'd132);
        chk("t4_last_instr", ifid_instr, 32'hA000_0084);
        step();
        chk("t4_drain_valid", {31'd0, ifid_valid}, 32'd0);
        chk("t4_drain_addr", imem_addr, 32'd136);
        drive(1'b0, 1'b1, 32'h0000_0040);
        step();
        chk("t4_resume_halted", {31'd0, halted}, 32'd0);
        chk("t4_resume_addr", imem_addr, 32'h0000_0040);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("t4_resume_pc", ifid_pc, 32'h0000_0040);
        chk("t4_resume_valid", {31'd0, ifid_valid}, 32'd1);
        drive(1'b0, 1'b1, 32'd200);
        step();
        chk("t4_far_halted", {31'd0, halted}, 32'd1);
        drive(1'b0, 1'b1, 32'd132);
        step();
        chk("t4_edge_run", {31'd0, halted}, 32'd0);
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("t4_edge_halt", {31'd0, halted}, 32'd1);
        chk("t4_edge_instr", ifid_instr, 32'hA000_0084);

        // Test 5: asynchronous reset mid-cycle at pc=20
        drive(1'b0, 1'b1, 32'd16);
        step();
        drive(1'b0, 1'b0, 32'h0);
        step();
        chk("t5_pre_addr", imem_addr, 32'd20);
        @(negedge clk); #2; rst_n = 1'b0; #1;
        chk("t5_addr", imem_addr, 32'h0);
        chk("t5_instr", ifid_instr, 32'h0000_0013);
        chk("t5_pc", ifid_pc, 32'h0);
        chk("t5_pc4", ifid_pc4, 32'h0);
        chk("t5_valid", {31'd0, ifid_valid}, 32'd0);
        @(negedge clk); rst_n = 1'b1;
        step();
        chk("t5_restart_pc", ifid_pc, 32'h0);
        chk("t5_restart_addr", imem_addr, 32'd4);

        // Test 6: instance B reset into halt, then redirect to 0
        chk("t6_halted", {31'd0, halted_b}, 32'd1);
        chk("t6_valid", {31'd0, ifid_valid_b}, 32'd0);
        @(negedge clk); #1; redirect_b = 1'b1; redirect_pc_b = 32'h0;
        step();
        chk("t6_run", {31'd0, halted_b}, 32'd0);
        chk("t6_addr", imem_addr_b, 32'h0);
        @(negedge clk); #1; redirect_b = 1'b0;
        step();
        chk("t6_fetch_pc", ifid_pc_b, 32'h0);
        chk("t6_fetch_instr", ifid_instr_b, 32'hA000_0000);
        chk("t6_fetch_valid", {31'd0, ifid_valid_b}, 32'd1);
        chk("t6_next_addr", imem_addr_b, 32'd4);

        @(negedge clk);
        cmp_en = 1'b0;
        #1;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
